// File: rtl/q_table_updater_pkg.sv
// ---------------------------------------------------------------------------
// rl_pkg : shared Q-learning types, FSM encoding and saturation helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rl_pkg;

   localparam int Q_W         = 16;
   localparam int FRAC_W      = 8;
   localparam int NUM_ACTIONS = 4;
   localparam int ACC_W       = 40;

   typedef logic signed [Q_W-1:0]   q_t;
   typedef q_t [NUM_ACTIONS-1:0]    q_row_t;
   typedef logic signed [ACC_W-1:0] acc_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MAX   = 3'd1,
      ST_TD    = 3'd2,
      ST_SCALE = 3'd3,
      ST_WRITE = 3'd4
   } upd_fsm_e;

   localparam acc_t C_Q_MAX = 40'sd32767;
   localparam acc_t C_Q_MIN = -40'sd32768;

   function automatic q_t sat16(input acc_t v);
      q_t r;
      if (v > C_Q_MAX) begin
         r = 16'sh7FFF;
      end else if (v < C_Q_MIN) begin
         r = 16'sh8000;
      end else begin
         r = v[Q_W-1:0];
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/q_table_updater_if.sv
// ---------------------------------------------------------------------------
// q_table_if : read port and update request bundle of the Q-table updater
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface q_table_if #(
   parameter int STATE_W = 4
);

   logic [STATE_W-1:0] rd_state;
   logic [63:0]        q_values;
   logic               upd_valid;
   logic               upd_ready;
   logic [STATE_W-1:0] upd_state;
   logic [STATE_W-1:0] upd_next_state;
   logic [3:0]         upd_action;
   logic [15:0]        reward;
   logic [15:0]        alpha;
   logic [15:0]        gamma;
   logic               done;
   logic               err;

   modport master (
      output rd_state, upd_valid, upd_state, upd_next_state, upd_action,
             reward, alpha, gamma,
      input  q_values, upd_ready, done, err
   );

   modport slave (
      input  rd_state, upd_valid, upd_state, upd_next_state, upd_action,
             reward, alpha, gamma,
      output q_values, upd_ready, done, err
   );

endinterface

`default_nettype wire

// File: rtl/q_max4.sv
// ---------------------------------------------------------------------------
// q_max4 : combinational signed maximum of a packed 4-entry Q row
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module q_max4
   import rl_pkg::*;
(
   input  q_row_t row,
   output q_t     max_val
);

   q_t m01;
   q_t m23;

   always_comb begin
      m01     = ($signed(row[1]) > $signed(row[0])) ? row[1] : row[0];
      m23     = ($signed(row[3]) > $signed(row[2])) ? row[3] : row[2];
      max_val = (m23 > m01) ? m23 : m01;
   end

endmodule

`default_nettype wire

// File: rtl/q_table_updater.sv
// ---------------------------------------------------------------------------
// q_table_updater : Q-table storage with registered read port and TD update FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module q_table_updater
   import rl_pkg::*;
#(
   parameter int NUM_STATES = 16,
   parameter int STATE_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   q_table_if.slave   bus
);

   upd_fsm_e           state_q, state_d;
   logic [STATE_W-1:0] s_q, s_d;
   logic [STATE_W-1:0] sn_q, sn_d;
   logic [1:0]         act_q, act_d;
   q_t                 reward_q, reward_d;
   logic [15:0]        alpha_q, alpha_d;
   logic [15:0]        gamma_q, gamma_d;
   q_t                 m_q, m_d;
   q_t                 qv_q, qv_d;
   acc_t               td_q, td_d;
   acc_t               delta_q, delta_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   q_row_t             q_values_q, q_values_d;
   q_row_t             table_q [NUM_STATES];
   q_row_t             table_d [NUM_STATES];

   q_row_t             row_next;
   q_t                 row_max;
   logic [1:0]         act_idx;
   logic               req_ok;
   acc_t               gamma_prod;
   acc_t               alpha_prod;

   q_max4 u_max (
      .row     (row_next),
      .max_val (row_max)
   );

   assign row_next = table_q[sn_q];

   always_comb begin
      act_idx = 2'd0;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
         if (bus.upd_action[i]) act_idx = 2'(i);
      end
      req_ok = $onehot(bus.upd_action)
            && (32'(bus.upd_state) < NUM_STATES)
            && (32'(bus.upd_next_state) < NUM_STATES);
   end

   // Both operands are 40-bit signed so the products are full precision.
   always_comb begin
      gamma_prod = acc_t'({24'd0, gamma_q}) * acc_t'({{(ACC_W-Q_W){m_q[Q_W-1]}}, m_q});
      alpha_prod = acc_t'({24'd0, alpha_q}) * td_q;
   end

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      sn_d     = sn_q;
      act_d    = act_q;
      reward_d = reward_q;
      alpha_d  = alpha_q;
      gamma_d  = gamma_q;
      m_d      = m_q;
      qv_d     = qv_q;
      td_d     = td_q;
      delta_d  = delta_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      table_d  = table_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.upd_valid) begin
               if (req_ok) begin
                  s_d      = bus.upd_state;
                  sn_d     = bus.upd_next_state;
                  act_d    = act_idx;
                  reward_d = bus.reward;
                  alpha_d  = bus.alpha;
                  gamma_d  = bus.gamma;
                  state_d  = ST_MAX;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_MAX: begin
            m_d     = row_max;
            qv_d    = table_q[s_q][act_q];
            state_d = ST_TD;
         end
         ST_TD: begin
            td_d    = acc_t'(reward_q) + (gamma_prod >>> FRAC_W) - acc_t'(qv_q);
            state_d = ST_SCALE;
         end
         ST_SCALE: begin
            delta_d = alpha_prod >>> FRAC_W;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            table_d[s_q][act_q] = sat16(acc_t'(qv_q) + delta_q);
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Reads sample table_q, so a same-edge write returns the old row.
   always_comb begin
      q_values_d = '0;
      if (32'(bus.rd_state) < NUM_STATES) q_values_d = table_q[bus.rd_state];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         s_q        <= '0;
         sn_q       <= '0;
         act_q      <= '0;
         reward_q   <= '0;
         alpha_q    <= '0;
         gamma_q    <= '0;
         m_q        <= '0;
         qv_q       <= '0;
         td_q       <= '0;
         delta_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         q_values_q <= '0;
         for (int i = 0; i < NUM_STATES; i++) table_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         sn_q       <= sn_d;
         act_q      <= act_d;
         reward_q   <= reward_d;
         alpha_q    <= alpha_d;
         gamma_q    <= gamma_d;
         m_q        <= m_d;
         qv_q       <= qv_d;
         td_q       <= td_d;
         delta_q    <= delta_d;
         done_q     <= done_d;
         err_q      <= err_d;
         q_values_q <= q_values_d;
         table_q    <= table_d;
      end
   end

   assign bus.q_values  = q_values_q;
   assign bus.upd_ready = (state_q == ST_IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_q_table_updater.sv
// ---------------------------------------------------------------------------
// tb_q_table_updater : directed self-checking bench for q_table_updater
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_q_table_updater;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   q_table_if #(.STATE_W(4)) bus ();

   q_table_updater #(
      .NUM_STATES (16),
      .STATE_W    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_update(input logic [3:0] s, input logic [3:0] sn,
                             input logic [3:0] act, input logic [15:0] r,
                             input logic [15:0] al, input logic [15:0] g,
                             output int lat);
      int n;
      @(negedge clk);
      bus.upd_state      = s;
      bus.upd_next_state = sn;
      bus.upd_action     = act;
      bus.reward         = r;
      bus.alpha          = al;
      bus.gamma          = g;
      bus.upd_valid      = 1'b1;
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
      bus.reward    = 16'hDEAD;
      lat = -1;
      n   = 0;
      while (lat < 0 && n < 10) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done) lat = n;
      end
   endtask

   task automatic read_row(input logic [3:0] st, output logic [63:0] row);
      @(negedge clk);
      bus.rd_state = st;
      @(posedge clk);
      #1;
      row = bus.q_values;
   endtask

   task automatic test_reset();
      logic [63:0] row;
      rst                = 1'b1;
      bus.rd_state       = '0;
      bus.upd_valid      = 1'b0;
      bus.upd_state      = '0;
      bus.upd_next_state = '0;
      bus.upd_action     = '0;
      bus.reward         = '0;
      bus.alpha          = '0;
      bus.gamma          = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.upd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=1", bus.upd_ready);
      end
      checks++;
      if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reset_done_err got=%b%b exp=00", bus.done, bus.err);
      end
      read_row(4'd0, row);
      checks++;
      if (row !== 64'h0) begin
         failures++;
         $display("FAIL reset_row0 got=%h exp=%h", row, 64'h0);
      end
   endtask

   task automatic test_update_basic();
      int lat;
      logic [63:0] row;
      run_update(4'd0, 4'd1, 4'b0001, 16'h0100, 16'h0080, 16'h00E0, lat);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL basic_latency got=%0d exp=4", lat);
      end
      checks++;
      if (bus.upd_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_ready_on_done got=%b exp=1", bus.upd_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL basic_done_pulse got=%b exp=0", bus.done);
      end
      read_row(4'd0, row);
      checks++;
      if (row !== 64'h0000_0000_0000_0080) begin
         failures++;
         $display("FAIL basic_row0 got=%h exp=%h", row, 64'h0000_0000_0000_0080);
      end
   endtask

   task automatic test_update_chain();
      int lat;
      logic [63:0] row;
      run_update(4'd1, 4'd0, 4'b0100, 16'h0000, 16'h0100, 16'h00E0, lat);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL chain_latency got=%0d exp=4", lat);
      end
      read_row(4'd1, row);
      checks++;
      if (row !== 64'h0000_0070_0000_0000) begin
         failures++;
         $display("FAIL chain_row1 got=%h exp=%h", row, 64'h0000_0070_0000_0000);
      end
   endtask

   task automatic test_back_to_back_saturation();
      int lat [4];
      logic [63:0] row;
      run_update(4'd2, 4'd3, 4'b0001, 16'h7FFF, 16'h0100, 16'h00E0, lat[0]);
      run_update(4'd2, 4'd2, 4'b0001, 16'h7FFF, 16'h0100, 16'h0100, lat[1]);
      run_update(4'd3, 4'd3, 4'b1000, 16'h8000, 16'h0100, 16'h0000, lat[2]);
      run_update(4'd4, 4'd4, 4'b0010, 16'h8000, 16'h0200, 16'h0000, lat[3]);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (lat[i] !== 4) begin
            failures++;
            $display("FAIL b2b_latency_%0d got=%0d exp=4", i, lat[i]);
         end
      end
      read_row(4'd2, row);
      checks++;
      if (row !== 64'h0000_0000_0000_7FFF) begin
         failures++;
         $display("FAIL sat_pos_row2 got=%h exp=%h", row, 64'h0000_0000_0000_7FFF);
      end
      read_row(4'd3, row);
      checks++;
      if (row !== 64'h8000_0000_0000_0000) begin
         failures++;
         $display("FAIL sat_neg_row3 got=%h exp=%h", row, 64'h8000_0000_0000_0000);
      end
      read_row(4'd4, row);
      checks++;
      if (row !== 64'h0000_0000_8000_0000) begin
         failures++;
         $display("FAIL sat_clip_row4 got=%h exp=%h", row, 64'h0000_0000_8000_0000);
      end
   endtask

   task automatic test_reject();
      int done_seen;
      @(negedge clk);
      bus.rd_state       = 4'd1;
      bus.upd_state      = 4'd1;
      bus.upd_next_state = 4'd0;
      bus.upd_action     = 4'b0011;
      bus.reward         = 16'h0100;
      bus.alpha          = 16'h0100;
      bus.gamma          = 16'h0000;
      bus.upd_valid      = 1'b1;
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
      checks++;
      if (bus.err !== 1'b1) begin
         failures++;
         $display("FAIL reject_err got=%b exp=1", bus.err);
      end
      checks++;
      if (bus.upd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reject_ready got=%b exp=1", bus.upd_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reject_err_pulse got=%b exp=0", bus.err);
      end
      done_seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.done) done_seen++;
      end
      checks++;
      if (done_seen !== 0) begin
         failures++;
         $display("FAIL reject_no_done got=%0d exp=0", done_seen);
      end
      checks++;
      if (bus.q_values !== 64'h0000_0070_0000_0000) begin
         failures++;
         $display("FAIL reject_row1 got=%h exp=%h", bus.q_values, 64'h0000_0070_0000_0000);
      end
   endtask

   task automatic test_read_during_write();
      int lat;
      @(negedge clk);
      bus.rd_state = 4'd0;
      run_update(4'd0, 4'd1, 4'b0001, 16'h0100, 16'h0100, 16'h0000, lat);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL rdw_latency got=%0d exp=4", lat);
      end
      checks++;
      if (bus.q_values !== 64'h0000_0000_0000_0080) begin
         failures++;
         $display("FAIL rdw_old got=%h exp=%h", bus.q_values, 64'h0000_0000_0000_0080);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.q_values !== 64'h0000_0000_0000_0100) begin
         failures++;
         $display("FAIL rdw_new got=%h exp=%h", bus.q_values, 64'h0000_0000_0000_0100);
      end
   endtask

   task automatic test_reset_abort();
      int done_seen;
      logic [63:0] row;
      @(negedge clk);
      bus.rd_state       = 4'd0;
      bus.upd_state      = 4'd5;
      bus.upd_next_state = 4'd5;
      bus.upd_action     = 4'b0001;
      bus.reward         = 16'h1000;
      bus.alpha          = 16'h0100;
      bus.gamma          = 16'h0000;
      bus.upd_valid      = 1'b1;
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.upd_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_busy got=%b exp=0", bus.upd_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.q_values !== 64'h0) begin
         failures++;
         $display("FAIL abort_qvalues got=%h exp=%h", bus.q_values, 64'h0);
      end
      checks++;
      if (bus.upd_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_ready got=%b exp=1", bus.upd_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.done) done_seen++;
      end
      checks++;
      if (done_seen !== 0) begin
         failures++;
         $display("FAIL abort_no_done got=%0d exp=0", done_seen);
      end
      read_row(4'd5, row);
      checks++;
      if (row !== 64'h0) begin
         failures++;
         $display("FAIL abort_row5 got=%h exp=%h", row, 64'h0);
      end
      read_row(4'd0, row);
      checks++;
      if (row !== 64'h0) begin
         failures++;
         $display("FAIL abort_row0_cleared got=%h exp=%h", row, 64'h0);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_update_basic();
      test_update_chain();
      test_back_to_back_saturation();
      test_reject();
      test_read_during_write();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
